// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg -- shared types and helpers for stream_mux_n.
//   lock_state_t : packet lock state (UNLOCKED / LOCKED)
//   rr_pick()    : rotating-priority search over a valid vector
package stream_mux_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Upper bound on channel count that rr_pick can search.
  localparam int RR_MAX_CH = 32;

  // Returns the first set bit of valid[n-1:0], starting the search at
  // ptr+1 and wrapping modulo n. Returns -1 when no bit is set.
  // The loop walks from the farthest candidate to the nearest, so the
  // nearest hit is the last assignment and therefore wins.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                 input int ptr, input int n);
    int idx;
    rr_pick = -1;
    for (int k = RR_MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/stream_mux_out_reg.sv
// stream_mux_out_reg -- single-entry output register slice.
//   clk, rst_n              : clock, async active-low reset
//   load                    : capture load_data/last/chan this edge
//   load_data/last/chan     : beat to capture
//   out_ready               : downstream accept
//   load_ok                 : register is free or draining this cycle
//   out_valid/data/last/chan: registered beat
// With load asserted only when load_ok=1 this gives full throughput:
// a beat leaving and a new beat entering in the same cycle.
module stream_mux_out_reg #(
  parameter int WIDTH = 100,
  parameter int SELW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic [SELW-1:0]  load_chan,
  input  logic             out_ready,
  output logic             load_ok,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [SELW-1:0]  out_chan
);

  assign load_ok = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
      out_chan  <= load_chan;
    end else if (out_ready) begin
      // Drained with nothing new: drop valid, keep payload as-is.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// stream_mux_n -- N-to-1 packet-aware stream multiplexer.
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_ready : per-channel handshake (N bits)
//   in_data           : channel i at [i*WIDTH +: WIDTH]
//   in_last           : per-channel end-of-packet
//   sel               : requested channel, sampled only when unlocked
//   rr_mode           : (STREAM_MUX_N_RR_EN only) round-robin grant
//   out_valid/ready   : output handshake
//   out_data/last/chan: registered beat and its source channel
// Once a multi-beat packet starts, the mux locks onto that channel until
// its last beat transfers. Build option: define STREAM_MUX_N_RR_EN to add
// the rr_mode input and the round-robin pointer.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 100,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  input  logic [SELW-1:0]    sel,
`ifdef STREAM_MUX_N_RR_EN
  input  logic               rr_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_chan
);

  localparam logic [SELW:0] N_L = (SELW+1)'(N);

  lock_state_t               state;
  logic [SELW-1:0]           lock_chan;
  logic [SELW-1:0]           cur;
  logic                      cur_ok;
  logic                      load_ok;
  logic                      xfer;
  logic [N-1:0][WIDTH-1:0]   in_vec;

  assign in_vec = in_data;

`ifdef STREAM_MUX_N_RR_EN
  logic [SELW-1:0] rr_ptr;
  int              rr_idx;
  always_comb rr_idx = rr_pick(RR_MAX_CH'(in_valid), int'(rr_ptr), N);
`endif

  // Current channel: latched while locked, else sel (or round-robin).
  // An out-of-range sel leaves cur_ok low so nothing is granted.
  always_comb begin
    cur    = sel;
    cur_ok = ({1'b0, sel} < N_L);
`ifdef STREAM_MUX_N_RR_EN
    if (rr_mode) begin
      cur    = SELW'(rr_idx);
      cur_ok = (rr_idx >= 0);
    end
`endif
    if (state == LOCKED) begin
      cur    = lock_chan;
      cur_ok = 1'b1;
    end
  end

  // rst_n gating keeps in_ready low for the whole reset, since the
  // cleared output register would otherwise report load_ok=1.
  always_comb begin
    in_ready = '0;
    if (rst_n && cur_ok && load_ok) in_ready[cur] = 1'b1;
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      lock_chan <= '0;
`ifdef STREAM_MUX_N_RR_EN
      rr_ptr    <= SELW'(N-1);
`endif
    end else if (xfer) begin
      case (state)
        UNLOCKED: begin
`ifdef STREAM_MUX_N_RR_EN
          // First beat of a packet moves the rotating priority.
          rr_ptr <= cur;
`endif
          if (!in_last[cur]) begin
            state     <= LOCKED;
            lock_chan <= cur;
          end
        end
        LOCKED: if (in_last[cur]) state <= UNLOCKED;
        default: state <= UNLOCKED;
      endcase
    end
  end

  stream_mux_out_reg #(.WIDTH(WIDTH), .SELW(SELW)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (xfer),
    .load_data (in_vec[cur]),
    .load_last (in_last[cur]),
    .load_chan (cur),
    .out_ready (out_ready),
    .load_ok   (load_ok),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_chan  (out_chan)
  );

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n -- directed bench for stream_mux_n (WIDTH=100, N=4).
// Stimulus pushes expected beats into a queue as each input beat is
// accepted; a negedge monitor pops and compares every output transfer.
module tb_stream_mux_n;
  localparam int W = 100, N = 4, SELW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_valid, in_ready, in_last;
  logic [N*W-1:0]   in_data;
  logic [SELW-1:0]  sel;
  logic             out_valid, out_ready, out_last;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_chan;
`ifdef STREAM_MUX_N_RR_EN
  logic             rr_mode;
`endif

  always #5 clk = ~clk;

  stream_mux_n #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .sel(sel),
`ifdef STREAM_MUX_N_RR_EN
    .rr_mode(rr_mode),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan)
  );

  typedef struct packed {
    logic [W-1:0]    d;
    logic            last;
    logic [SELW-1:0] ch;
  } beat_t;

  beat_t sbq[$];
  int    n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_beat: got data %0h chan %0d expected none", out_data, out_chan);
      end else begin
        beat_t e;
        e = sbq.pop_front();
        chk("sb_data", 128'(out_data), 128'(e.d));
        chk("sb_last", 128'(out_last), 128'(e.last));
        chk("sb_chan", 128'(out_chan), 128'(e.ch));
      end
    end
  end

  // Present one beat on ch, wait (bounded) for acceptance, push expected.
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int ch, input logic [W-1:0] d, input logic last, output int waits);
    int n;
    n = 0;
    in_valid[ch] = 1'b1;
    in_data[ch*W +: W] = d;
    in_last[ch] = last;
    @(negedge clk);
    while (!in_ready[ch] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[ch]) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: ch%0d got no in_ready expected in_ready within 50 cycles", ch);
    end else begin
      sbq.push_back(beat_t'{d: d, last: last, ch: SELW'(ch)});
    end
    waits = n;
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, total;
    logic [127:0] r;
    logic [W-1:0] a1, a2;
    rst_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0; sel = '0; out_ready = 1'b1;
`ifdef STREAM_MUX_N_RR_EN
    rr_mode = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_out_last",  128'(out_last),  128'(0));
    chk("rst_out_chan",  128'(out_chan),  128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Single-beat packet on ch2, one-cycle latency
    sel = 2'd2;
    send(2, 100'hDEADBEEF, 1'b1, w);
    chk("lat_valid", 128'(out_valid), 128'(1));
    chk("lat_data",  128'(out_data),  128'h DEADBEEF);
    chk("lat_chan",  128'(out_chan),  128'(2));
    chk("lat_last",  128'(out_last),  128'(1));

    // 3-beat packet on ch1, sel moves to 3 mid-packet while ch3 valid
    sel = 2'd1;
    in_valid[3] = 1'b1; in_data[3*W +: W] = 100'hC3C3C3; in_last[3] = 1'b1;
    send(1, 100'h5EAF00D, 1'b0, w);
    sel = 2'd3;
    send(1, 100'h5EAF00E, 1'b0, w);
    chk("locked_ready", 128'(in_ready), 128'(4'b0010));
    send(1, 100'h5EAF00F, 1'b1, w);
    send(3, 100'hC3C3C3, 1'b1, w);
    chk("ch3_next_cycle_waits", 128'(w), 128'(0));

    // Back-pressure: hold for 3 cycles, pending beat must not be lost
    @(posedge clk); #1 out_ready = 1'b0;
    sel = 2'd0;
    a1 = 100'hA1A1; a2 = 100'hA2A2;
    send(0, a1, 1'b1, w);
    in_valid[0] = 1'b1; in_data[0 +: W] = a2; in_last[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_data",  128'(out_data),  128'(a1));
      chk("stall_chan",  128'(out_chan),  128'(0));
      chk("stall_last",  128'(out_last),  128'(1));
      chk("stall_ready", 128'(in_ready),  128'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(0, a2, 1'b1, w);
    @(posedge clk); #1;
    chk("drain_valid_low", 128'(out_valid), 128'(0));
    chk("drain_data_kept", 128'(out_data),  128'(a2));

    // in_ready independent of in_valid; reset mid-packet
    sel = 2'd3;
    #1 chk("ready_no_valid", 128'(in_ready), 128'(4'b1000));
    @(posedge clk); #1;
    out_ready = 1'b0; sel = 2'd0;
    send(0, 100'hB0, 1'b0, w);
    in_valid[0] = 1'b1; in_data[0 +: W] = 100'hB1; in_last[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 128'(out_valid), 128'(0));
    chk("rstmid_out_data",  128'(out_data),  128'(0));
    chk("rstmid_in_ready",  128'(in_ready),  128'(0));
    sbq.delete();
    @(posedge clk); #1;
    chk("rstmid_in_ready_hold", 128'(in_ready), 128'(0));
    rst_n = 1'b1; in_valid = '0; out_ready = 1'b1; sel = 2'd1;
    #1 chk("unlocked_after_rst", 128'(in_ready), 128'(4'b0010));
    @(posedge clk); #1;
    send(1, 100'hD1, 1'b1, w);

    // 100 back-to-back single-beat packets on ch0
    sel = 2'd0; total = 0;
    for (int i = 0; i < 100; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(0, r[W-1:0], 1'b1, w);
      total += w;
    end
    chk("burst_no_bubble", 128'(total), 128'(0));
    repeat (3) @(posedge clk);
    #1 chk("burst_drained", 128'(sbq.size()), 128'(0));

`ifdef STREAM_MUX_N_RR_EN
    begin
      int rr_exp[9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      rr_mode = 1'b1; in_last = '1; in_valid = 4'b1111;
      for (int c = 0; c < N; c++) in_data[c*W +: W] = W'(32'hC0 + c);
      for (int k = 0; k < 9; k++) begin
        if (k == 5) in_valid = 4'b1010;
        @(negedge clk);
        chk("rr_grant", 128'(in_ready), 128'(1) << rr_exp[k]);
        sbq.push_back(beat_t'{d: W'(32'hC0 + rr_exp[k]), last: 1'b1, ch: SELW'(rr_exp[k])});
        @(posedge clk); #1;
      end
      in_valid = '0; rr_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rr_drained", 128'(sbq.size()), 128'(0));
    end
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
